// File: rtl/dark_channel_pipe.sv
// dark_channel_pipe: 2-stage edge-aware dark-channel estimator; DARK_STATS_EN adds the edge_cnt counter
module dark_channel_pipe #(
    parameter int DW  = 8,
    parameter int NCH = 3,
    parameter int ETH = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*9*DW-1:0]   win_data,
    input  logic                  cfg_eth_we,
    input  logic [DW-1:0]         cfg_eth,
    input  logic                  cfg_noedge,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_dark,
    output logic                  out_edge
`ifdef DARK_STATS_EN
    ,
    output logic [31:0]           edge_cnt
`endif
);
    logic en1, en2, sel;
    logic s1_valid_q, s1_valid_d, noedge_q, noedge_d;
    logic out_valid_q, out_valid_d, out_edge_q, out_edge_d;
    logic [NCH-1:0] edg_q, edg_d;
    logic [DW-1:0] thr_q, thr_d, out_dark_q, out_dark_d, vmin;
    logic [DW-1:0] nmin_q [NCH];
    logic [DW-1:0] nmin_d [NCH];
    logic [DW-1:0] ctr_q [NCH];
    logic [DW-1:0] ctr_d [NCH];
`ifdef DARK_STATS_EN
    logic [31:0] edge_cnt_q, edge_cnt_d;
`endif

    function automatic logic [DW-1:0] tap(input logic [9*DW-1:0] w, input int k);
        return w[k*DW +: DW];
    endfunction

    function automatic logic [DW:0] absd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[DW] ? -d : d;
    endfunction

    function automatic logic [DW-1:0] nmin_f(input logic [9*DW-1:0] w);
        logic [DW-1:0] m;
        m = tap(w, 0);
        for (int k = 1; k < 9; k++)
            if (k != 4 && tap(w, k) < m) m = tap(w, k);
        return m;
    endfunction

    // opposing tap pairs through the centre: a-i, b-h, c-g, d-f
    function automatic logic edge_f(input logic [9*DW-1:0] w, input logic [DW-1:0] t);
        logic e;
        e = 1'b0;
        for (int k = 0; k < 4; k++)
            e = e | (absd(tap(w, k), tap(w, 8 - k)) > {1'b0, t});
        return e;
    endfunction

    always_comb begin
        en2 = !out_valid_q || out_ready;
        en1 = !s1_valid_q || en2;
        in_ready = en1;
        thr_d = cfg_eth_we ? cfg_eth : thr_q;
        s1_valid_d = en1 ? in_valid : s1_valid_q;
        noedge_d = en1 ? cfg_noedge : noedge_q;
        edg_d = edg_q;
        for (int c = 0; c < NCH; c++) begin
            nmin_d[c] = en1 ? nmin_f(win_data[c*9*DW +: 9*DW]) : nmin_q[c];
            ctr_d[c] = en1 ? tap(win_data[c*9*DW +: 9*DW], 4) : ctr_q[c];
            edg_d[c] = en1 ? edge_f(win_data[c*9*DW +: 9*DW], thr_q) : edg_q[c];
        end
        sel = |edg_q && !noedge_q;
        vmin = '1;
        for (int c = 0; c < NCH; c++)
            if ((sel ? ctr_q[c] : nmin_q[c]) < vmin) vmin = sel ? ctr_q[c] : nmin_q[c];
        out_valid_d = en2 ? s1_valid_q : out_valid_q;
        out_dark_d = en2 ? vmin : out_dark_q;
        out_edge_d = en2 ? sel : out_edge_q;
`ifdef DARK_STATS_EN
        edge_cnt_d = (out_valid_q && out_ready && out_edge_q && edge_cnt_q != '1) ? edge_cnt_q + 32'd1 : edge_cnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            noedge_q    <= 1'b0;
            edg_q       <= '0;
            nmin_q      <= '{default: '0};
            ctr_q       <= '{default: '0};
            thr_q       <= DW'(ETH);
            out_valid_q <= 1'b0;
            out_dark_q  <= '0;
            out_edge_q  <= 1'b0;
`ifdef DARK_STATS_EN
            edge_cnt_q  <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            noedge_q    <= noedge_d;
            edg_q       <= edg_d;
            nmin_q      <= nmin_d;
            ctr_q       <= ctr_d;
            thr_q       <= thr_d;
            out_valid_q <= out_valid_d;
            out_dark_q  <= out_dark_d;
            out_edge_q  <= out_edge_d;
`ifdef DARK_STATS_EN
            edge_cnt_q  <= edge_cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_dark  = out_dark_q;
    assign out_edge  = out_edge_q;
`ifdef DARK_STATS_EN
    assign edge_cnt  = edge_cnt_q;
`endif
endmodule
